mfm_write_precomp: RTL and testbench

//  Write-precompensation and pulse-timing stage directly downstream of the serial MFM encoder.

---
 rtl/mfm_write_precomp.sv | 115 +++++++++++
 tb/tb_mfm_write_precomp.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfm_write_precomp.sv
// MFM write precompensation: per-cell early/late shift and fixed-width WDATA pulse.
// Define MFM_WRITE_PRECOMP_EN to enable early/late shifting (else all launches nominal).
module mfm_write_precomp #(
  parameter int MAX_PRECOMP = 7,
  parameter int PULSE_CLKS  = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cell_bit,
  input  logic             cell_valid,
  input  logic [3:0]       precomp_clks,
  output logic             wr_pulse,
  output logic             pulse_pending,
  output logic             overrun,
  output logic [CNT_W-1:0] pulse_count
);

  localparam int TW = $clog2(2 * MAX_PRECOMP + 2);
  localparam int WW = $clog2(PULSE_CLKS + 1);

  logic [4:0]    win;
  logic          shifted;
  logic [TW-1:0] timer;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] launch_val;
  logic          launch;
  logic          fire;

`ifdef MFM_WRITE_PRECOMP_EN
  int pe;
  int tval;

  always_comb begin
    pe = int'(precomp_clks);
    if (pe > MAX_PRECOMP)
      pe = MAX_PRECOMP;
    tval = MAX_PRECOMP;
    if (win[0] && !win[4])
      tval = MAX_PRECOMP - pe;
    else if (win[4] && !win[0])
      tval = MAX_PRECOMP + pe;
    launch_val = TW'(tval);
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{precomp_clks, win[4]};

  always_comb begin
    launch_val = TW'(MAX_PRECOMP);
  end
`endif

  // A launch supersedes any pending countdown, including one due this edge.
  always_comb begin
    launch = shifted && win[2];
    fire   = !launch && pulse_pending && (timer == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win           <= '0;
      shifted       <= 1'b0;
      timer         <= '0;
      pulse_pending <= 1'b0;
      wr_pulse      <= 1'b0;
      wcnt          <= '0;
      overrun       <= 1'b0;
      pulse_count   <= '0;
    end else if (!enable) begin
      win           <= '0;
      shifted       <= 1'b0;
      timer         <= '0;
      pulse_pending <= 1'b0;
      wr_pulse      <= 1'b0;
      wcnt          <= '0;
    end else begin
      shifted <= cell_valid;
      if (cell_valid)
        win <= {win[3:0], cell_bit};

      if (launch) begin
        timer         <= launch_val;
        pulse_pending <= 1'b1;
        if (pulse_pending)
          overrun <= 1'b1;
      end else if (pulse_pending) begin
        if (timer == '0)
          pulse_pending <= 1'b0;
        else
          timer <= timer - 1'b1;
      end

      // Firing into a live pulse stretches it rather than adding an edge.
      if (fire) begin
        wr_pulse <= 1'b1;
        wcnt     <= WW'(PULSE_CLKS);
        if (wr_pulse)
          overrun <= 1'b1;
        else
          pulse_count <= pulse_count + 1'b1;
      end else if (wr_pulse) begin
        if (wcnt == WW'(1)) begin
          wr_pulse <= 1'b0;
          wcnt     <= '0;
        end else begin
          wcnt <= wcnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mfm_write_precomp.sv
// Scoreboard bench for mfm_write_precomp: expected rise edges queued per driven cell.
// Follows the MFM_WRITE_PRECOMP_EN setting of the build.
module tb_mfm_write_precomp;

  localparam int MAXP = 7;
  localparam int PW   = 4;
`ifdef MFM_WRITE_PRECOMP_EN
  localparam bit PC_ON = 1'b1;
`else
  localparam bit PC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cell_bit = 1'b0;
  logic        cell_valid = 1'b0;
  logic [3:0]  precomp_clks = 4'd0;
  logic        wr_pulse;
  logic        pulse_pending;
  logic        overrun;
  logic [15:0] pulse_count;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int rise_q[$];
  int exp_cnt = 0;
  int exp_e;
  int rise_at = 0;
  bit mon_en = 1'b1;
  logic prev_wp = 1'b0;
  logic [4:0] mwin = '0;

  mfm_write_precomp #(
    .MAX_PRECOMP(MAXP),
    .PULSE_CLKS(PW),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .cell_bit(cell_bit),
    .cell_valid(cell_valid),
    .precomp_clks(precomp_clks),
    .wr_pulse(wr_pulse),
    .pulse_pending(pulse_pending),
    .overrun(overrun),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_pulse && !prev_wp) begin
        rise_q.push_back(cyc);
        rise_at = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rise: rose at edge %0d, required none", cyc);
        end else begin
          exp_e = exp_q.pop_front();
          if (cyc !== exp_e) begin
            n_err++;
            $display("FAIL rise_edge: got %0d, required %0d", cyc, exp_e);
          end
        end
      end
      if (!wr_pulse && prev_wp) begin
        n_cmp++;
        if (cyc - rise_at !== PW) begin
          n_err++;
          $display("FAIL pulse_width: got %0d, required %0d", cyc - rise_at, PW);
        end
      end
    end
    prev_wp = wr_pulse;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    cell_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rise_q.delete();
    mwin = '0;
    exp_cnt = 0;
  endtask

  task automatic send_cell(input logic b);
    int t;
    int pe;
    int adj;
    @(negedge clk);
    cell_bit = b;
    cell_valid = 1'b1;
    t = cyc + 1;
    mwin = {mwin[3:0], b};
    if (mwin[2]) begin
      pe = 0;
      if (PC_ON)
        pe = (int'(precomp_clks) > MAXP) ? MAXP : int'(precomp_clks);
      adj = 0;
      if (mwin[0] && !mwin[4])
        adj = -pe;
      else if (mwin[4] && !mwin[0])
        adj = pe;
      exp_q.push_back(t + 2 + MAXP + adj);
      exp_cnt++;
    end
    @(negedge clk);
    cell_valid = 1'b0;
    cell_bit = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 4;
    if (wr_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wr_pulse: got %b, required 0", wr_pulse);
    end
    if (pulse_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pending: got %b, required 0", pulse_pending);
    end
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_overrun: got %b, required 0", overrun);
    end
    if (pulse_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d, required 0", pulse_count);
    end
  endtask

  task automatic test_nominal_stream();
    int d;
    do_reset();
    precomp_clks = 4'd3;
    for (int i = 0; i < 24; i++)
      send_cell(i % 2 == 0);
    repeat (40) @(negedge clk);
    n_cmp += 4;
    if (pulse_count !== 16'd11) begin
      n_err++;
      $display("FAIL stream_count: got %0d, required 11", pulse_count);
    end
    if (exp_cnt !== 11) begin
      n_err++;
      $display("FAIL stream_model_count: got %0d, required 11", exp_cnt);
    end
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL stream_missing: got %0d left, required 0", exp_q.size());
    end
    d = (rise_q.size() >= 2) ? rise_q[$] - rise_q[$-1] : -1;
    if (d !== 16) begin
      n_err++;
      $display("FAIL stream_spacing: got %0d, required 16", d);
    end
  endtask

  task automatic test_shift(input logic [3:0] p, input int spacing);
    bit pat[10];
    int d;
    do_reset();
    precomp_clks = p;
    pat = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++)
      send_cell(pat[i]);
    repeat (30) @(negedge clk);
    n_cmp += 3;
    if (pulse_count !== 16'd2) begin
      n_err++;
      $display("FAIL shift_count p=%0d: got %0d, required 2", p, pulse_count);
    end
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL shift_missing p=%0d: got %0d left, required 0", p, exp_q.size());
    end
    d = (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : -1;
    if (d !== spacing) begin
      n_err++;
      $display("FAIL shift_spacing p=%0d: got %0d, required %0d", p, d, spacing);
    end
  endtask

  task automatic test_flush();
    do_reset();
    precomp_clks = 4'd3;
    send_cell(1'b1);
    send_cell(1'b0);
    @(negedge clk);
    cell_bit = 1'b1;
    cell_valid = 1'b1;
    @(negedge clk);
    cell_valid = 1'b0;
    cell_bit = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pulse_pending !== 1'b1) begin
      n_err++;
      $display("FAIL flush_launch: got %b, required 1", pulse_pending);
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (pulse_pending !== 1'b0) begin
      n_err++;
      $display("FAIL flush_pending: got %b, required 0", pulse_pending);
    end
    if (wr_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL flush_wr_pulse: got %b, required 0", wr_pulse);
    end
    repeat (25) @(negedge clk);
    n_cmp += 2;
    if (pulse_count !== 16'd0) begin
      n_err++;
      $display("FAIL flush_count: got %0d, required 0", pulse_count);
    end
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL flush_overrun: got %b, required 0", overrun);
    end
    enable = 1'b1;
  endtask

  task automatic test_overrun();
    do_reset();
    mon_en = 1'b0;
    precomp_clks = 4'd3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cell_valid = 1'b1;
      cell_bit = (i % 2 == 0);
    end
    @(negedge clk);
    cell_valid = 1'b0;
    cell_bit = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 3;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
    if (wr_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_flush_pulse: got %b, required 0", wr_pulse);
    end
    if (pulse_pending !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_flush_pending: got %b, required 0", pulse_pending);
    end
    do_reset();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal_stream();
    test_shift(4'd3, PC_ON ? 22 : 16);
    test_shift(4'd15, PC_ON ? 30 : 16);
    test_flush();
    test_overrun();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
